// File: rtl/sequential_divider_unit_if.sv
// Request/result bundle between the datapath controller and the sequential divider.
// start is sampled only while the divider is idle; ready is a one-cycle pulse marking quotient/remainder/div_by_zero valid.
interface sequential_divider_unit_if #(
  parameter int WORD_LENGTH = 8
) ();
  logic                   start;
  logic [WORD_LENGTH-1:0] dividend;
  logic [WORD_LENGTH-1:0] divisor;
  logic [WORD_LENGTH-1:0] quotient;
  logic [WORD_LENGTH-1:0] remainder;
  logic                   busy;
  logic                   ready;
  logic                   div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, ready, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, ready, div_by_zero
  );
endinterface

// File: rtl/sequential_divider_unit.sv
// Unsigned restoring divider, one quotient bit per clock; results are registered
// and announced by a single-cycle ready pulse.
module sequential_divider_unit #(
  parameter int WORD_LENGTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sys_reset,
  sequential_divider_unit_if.slave bus,
  output logic [1:0]               dbg_state_o
);
  localparam int W  = WORD_LENGTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    div_q, div_d;
  logic [W-1:0]    quotient_q, quotient_d;
  logic [W-1:0]    remainder_q, remainder_d;
  logic            dbz_q, dbz_d;

  // The trial value is W+1 bits wide; the kept partial remainder is always
  // below the divisor, so W bits hold it. diff[W+1:W] is zero exactly when T>=D.
  logic [W:0]      trial;
  logic [W+1:0]    diff;
  logic            ge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      work_q      <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      work_q      <= work_d;
      div_q       <= div_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    work_d      = work_q;
    div_d       = div_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    trial = {rem_q, work_q[W-1]};
    diff  = {1'b0, trial} - {2'b00, div_q};
    ge    = ~|diff[W+1:W];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dbz_d = 1'b0;
          if (bus.divisor != '0) begin
            div_d   = bus.divisor;
            work_d  = bus.dividend;
            rem_d   = '0;
            count_d = '0;
            state_d = DIVIDE;
          end else begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DIVIDE: begin
        if (ge) begin
          rem_d  = diff[W-1:0];
          work_d = {work_q[W-2:0], 1'b1};
        end else begin
          rem_d  = trial[W-1:0];
          work_d = {work_q[W-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
          state_d     = DONE;
          quotient_d  = work_d;
          remainder_d = rem_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Synchronous clear wins over everything, including an in-flight divide.
    if (sys_reset) begin
      state_d     = IDLE;
      count_d     = '0;
      rem_d       = '0;
      work_d      = '0;
      div_d       = '0;
      quotient_d  = '0;
      remainder_d = '0;
      dbz_d       = 1'b0;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q == DIVIDE);
  assign bus.ready       = (state_q == DONE);
  assign dbg_state_o     = state_q;
endmodule
